// File: rtl/edge_to_level.sv
// rtl/edge_to_level.sv - rise/fall request pulses to a glitch-free level with min high/low hold
// Holds each level for a programmable minimum time and queues one early opposite request.
module edge_to_level #(
  parameter int MIN_HIGH   = 4,
  parameter int MIN_LOW    = 4,
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic rise_i,
  input  logic fall_i,
  output logic level_o,
  output logic busy_o,
  output logic pending_o,
  output logic drop_o
);

  typedef enum logic [1:0] {
    LOW_IDLE  = 2'd0,
    LOW_HOLD  = 2'd1,
    HIGH_IDLE = 2'd2,
    HIGH_HOLD = 2'd3
  } state_t;

  localparam logic [7:0] HIGH_LOAD   = 8'(MIN_HIGH - 1);
  localparam logic [7:0] LOW_LOAD    = 8'(MIN_LOW - 1);
  localparam state_t     RESET_STATE = INIT_LEVEL ? HIGH_IDLE : LOW_IDLE;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        level_q, level_d;
  logic        busy_q, busy_d;
  logic        pending_q, pending_d;
  logic        drop_q, drop_d;

  logic        level_now;
  logic        in_hold;
  logic        conflict;
  logic        opp_req;
  logic        same_req;
  logic        do_toggle;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    drop_d    = 1'b0;
    do_toggle = 1'b0;

    level_now = (state_q == HIGH_IDLE) || (state_q == HIGH_HOLD);
    in_hold   = (state_q == LOW_HOLD) || (state_q == HIGH_HOLD);
    conflict  = rise_i & fall_i;
    opp_req   = ~conflict & (level_now ? fall_i : rise_i);
    same_req  = ~conflict & (level_now ? rise_i : fall_i);

    // Classify this cycle's request first, so a request landing on the
    // final hold cycle is folded into the exit decision below.
    if (conflict) begin
      drop_d = 1'b1;
    end else if (in_hold) begin
      if (opp_req) begin
        if (pending_q) drop_d = 1'b1;
        else           pending_d = 1'b1;
      end else if (same_req) begin
        if (pending_q) pending_d = 1'b0;
        else           drop_d = 1'b1;
      end
    end else begin
      if (opp_req)       do_toggle = 1'b1;
      else if (same_req) drop_d = 1'b1;
    end

    if (in_hold) begin
      if (cnt_q == 8'd0) begin
        if (pending_d) do_toggle = 1'b1;
        else           state_d = level_now ? HIGH_IDLE : LOW_IDLE;
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end

    if (do_toggle) begin
      pending_d = 1'b0;
      state_d   = level_now ? LOW_HOLD : HIGH_HOLD;
      cnt_d     = level_now ? LOW_LOAD : HIGH_LOAD;
    end

    level_d = (state_d == HIGH_IDLE) || (state_d == HIGH_HOLD);
    busy_d  = (state_d == LOW_HOLD) || (state_d == HIGH_HOLD);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= RESET_STATE;
      cnt_q     <= 8'd0;
      level_q   <= INIT_LEVEL;
      busy_q    <= 1'b0;
      pending_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
      drop_q    <= drop_d;
    end
  end

  assign level_o   = level_q;
  assign busy_o    = busy_q;
  assign pending_o = pending_q;
  assign drop_o    = drop_q;

endmodule

// File: tb/tb_edge_to_level.sv
// tb/tb_edge_to_level.sv - scoreboard bench for edge_to_level
// Expected {level,busy,pending,drop} per cycle is queued by stimulus and checked by a monitor.
module tb_edge_to_level;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic rise_a = 1'b0, fall_a = 1'b0;
  logic rise_b = 1'b0, fall_b = 1'b0;
  logic la, ba, pa, da;
  logic lb, bb, pb, db;

  int errors = 0;
  int checks = 0;
  int step_id = 0;

  typedef struct packed {
    logic        sel;
    logic [3:0]  exp;
    logic [15:0] id;
  } sb_entry_t;

  sb_entry_t sb[$];

  always #5 clk = ~clk;

  edge_to_level #(.MIN_HIGH(4), .MIN_LOW(4), .INIT_LEVEL(1'b0)) dut_a (
    .clk(clk), .reset(reset), .rise_i(rise_a), .fall_i(fall_a),
    .level_o(la), .busy_o(ba), .pending_o(pa), .drop_o(da)
  );

  edge_to_level #(.MIN_HIGH(1), .MIN_LOW(1), .INIT_LEVEL(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rise_i(rise_b), .fall_i(fall_b),
    .level_o(lb), .busy_o(bb), .pending_o(pb), .drop_o(db)
  );

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lvl/busy/pend/drop=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: one output sample per cycle, just after the active edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      sb_entry_t e;
      logic [3:0] act;
      e = sb.pop_front();
      act = e.sel ? {lb, bb, pb, db} : {la, ba, pa, da};
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL step%0d dut_%s: got lvl/busy/pend/drop=%b expected=%b",
                 e.id, e.sel ? "b" : "a", act, e.exp);
      end
    end
  end

  task automatic step(input logic sel, input logic r, input logic f, input logic [3:0] exp);
    sb_entry_t e;
    @(negedge clk);
    rise_a = sel ? 1'b0 : r;
    fall_a = sel ? 1'b0 : f;
    rise_b = sel ? r : 1'b0;
    fall_b = sel ? f : 1'b0;
    e.sel = sel;
    e.exp = exp;
    e.id  = 16'(step_id);
    sb.push_back(e);
    step_id++;
  endtask

  initial begin
    #3;
    chk("reset_a", {la, ba, pa, da}, 4'b0000);
    chk("reset_b", {lb, bb, pb, db}, 4'b0000);
    @(negedge clk);
    reset = 1'b1;

    // rise, queued fall lands exactly MIN_HIGH after the rise
    step(0, 1, 0, 4'b1100);
    step(0, 0, 0, 4'b1100);
    step(0, 0, 1, 4'b1110);
    step(0, 0, 0, 4'b1110);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0000);
    // conflict while idle
    step(0, 1, 1, 4'b0001);
    step(0, 0, 0, 4'b0000);
    // conflict during hold with pending: ignored, pending kept
    step(0, 1, 0, 4'b1100);
    step(0, 0, 1, 4'b1110);
    step(0, 1, 1, 4'b1111);
    step(0, 0, 0, 4'b1110);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0000);
    // cancel a pending fall, then redundant rise in HIGH_IDLE
    step(0, 1, 0, 4'b1100);
    step(0, 0, 0, 4'b1100);
    step(0, 0, 1, 4'b1110);
    step(0, 1, 0, 4'b1100);
    step(0, 0, 0, 4'b1000);
    step(0, 1, 0, 4'b1001);
    step(0, 0, 0, 4'b1000);
    // redundant opposite while pending, then request on the final hold cycle
    step(0, 0, 1, 4'b0100);
    step(0, 1, 0, 4'b0110);
    step(0, 1, 0, 4'b0111);
    step(0, 0, 0, 4'b0110);
    step(0, 0, 0, 4'b1100);
    step(0, 0, 0, 4'b1100);
    step(0, 0, 0, 4'b1100);
    step(0, 0, 0, 4'b1100);
    step(0, 0, 1, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0100);
    step(0, 0, 0, 4'b0000);
    // redundant fall in LOW_IDLE
    step(0, 0, 1, 4'b0001);
    step(0, 0, 0, 4'b0000);

    // MIN=1: alternating requests toggle every cycle, never dropped
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) step(1, 1, 0, 4'b1100);
      else            step(1, 0, 1, 4'b0100);
    end
    step(1, 0, 0, 4'b0000);

    // async reset mid-hold with pending
    step(0, 1, 0, 4'b1100);
    step(0, 0, 1, 4'b1110);
    @(negedge clk);
    #2;
    reset = 1'b0;
    rise_a = 1'b0; fall_a = 1'b0; rise_b = 1'b0; fall_b = 1'b0;
    #1;
    chk("async_reset_a", {la, ba, pa, da}, 4'b0000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 4'b0000);

    begin
      int budget;
      budget = 0;
      while (sb.size() > 0 && budget < 10) begin
        @(posedge clk);
        budget++;
      end
      #2;
      if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
